// File: rtl/tl45_alu.sv
// TL45 execute stage: single-cycle ALU, branch resolution, pass-through of
// memory/IO ops, and a 32-cycle iterative shift-add multiplier.
module tl45_alu (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    output logic        o_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_flush,
    input  logic [4:0]  i_opcode,
    input  logic [3:0]  i_dr,
    input  logic [31:0] i_sr1_val,
    input  logic [31:0] i_sr2_val,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_pc,
    output logic [4:0]  o_buf_opcode,
    output logic [3:0]  o_buf_dr,
    output logic [31:0] o_buf_sr1_val,
    output logic [31:0] o_buf_sr2_val,
    output logic [31:0] o_buf_imm,
    output logic [31:0] o_buf_pc,
    output logic [3:0]  o_fwd_dr,
    output logic [31:0] o_fwd_val,
    output logic        o_ld_newpc,
    output logic [31:0] o_br_pc
);

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_MUL  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_XOR  = 5'h06;
    localparam logic [4:0] OP_SHL  = 5'h07;
    localparam logic [4:0] OP_SHR  = 5'h08;
    localparam logic [4:0] OP_SHRA = 5'h09;
    localparam logic [4:0] OP_BZ   = 5'h0A;
    localparam logic [4:0] OP_BNZ  = 5'h0B;
    localparam logic [4:0] OP_JMP  = 5'h0C;
    localparam logic [4:0] OP_CALL = 5'h0D;
    localparam logic [4:0] OP_SW   = 5'h15;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] mcand, mplier, prod, mul_pc;
    logic [3:0]  mul_dr;
    logic        flush_reg;

    logic [31:0] a, b, alu_res, mul_res, br_target;
    logic        is_alu, is_mul, is_pass, br_taken, accept, mul_start, mul_done;

    logic        buf_ld;
    logic [4:0]  nx_opcode;
    logic [3:0]  nx_dr;
    logic [31:0] nx_sr1, nx_sr2, nx_imm, nx_pc;

    assign a         = i_sr1_val;
    assign b         = i_sr2_val + i_imm;
    assign is_mul    = (i_opcode == OP_MUL);
    assign is_alu    = (i_opcode >= OP_ADD) && (i_opcode <= OP_SHRA) && !is_mul;
    assign is_pass   = (i_opcode >= OP_CALL) && (i_opcode <= OP_SW);
    assign accept    = (state == IDLE) && !i_pipe_stall && !i_pipe_flush && !is_mul;
    assign mul_start = (state == IDLE) && is_mul && !i_pipe_stall;
    assign mul_done  = (state == MUL_BUSY) && (cnt == 5'd31) && !i_pipe_stall;
    // Current multiplier bit folded in combinationally so the last step lands in o_buf directly.
    assign mul_res   = prod + (mplier[0] ? mcand : 32'h0);

    assign o_pipe_stall = i_pipe_stall || ((state == MUL_BUSY) && (cnt != 5'd31))
                          || ((state == IDLE) && is_mul);
    assign o_pipe_flush = flush_reg || i_pipe_flush;

    always_comb begin
        alu_res = 32'h0;
        case (i_opcode)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = a << b[4:0];
            OP_SHR:  alu_res = a >> b[4:0];
            OP_SHRA: alu_res = $unsigned($signed(a) >>> b[4:0]);
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        br_taken  = 1'b0;
        br_target = i_pc + i_imm;
        case (i_opcode)
            OP_BZ:   br_taken = (a == 32'h0);
            OP_BNZ:  br_taken = (a != 32'h0);
            OP_JMP: begin
                br_taken  = 1'b1;
                br_target = a + i_imm;
            end
            default: br_taken = 1'b0;
        endcase
    end

    // Anything not ALU or pass-through (branches, MUL start, undefined) loads a bubble.
    always_comb begin
        buf_ld    = 1'b0;
        nx_opcode = 5'h0;
        nx_dr     = 4'h0;
        nx_sr1    = 32'h0;
        nx_sr2    = 32'h0;
        nx_imm    = 32'h0;
        nx_pc     = 32'h0;
        if (mul_done) begin
            buf_ld    = 1'b1;
            nx_opcode = OP_MUL;
            nx_dr     = mul_dr;
            nx_sr1    = mul_res;
            nx_pc     = mul_pc;
        end else if ((state == IDLE) && !i_pipe_stall) begin
            buf_ld = 1'b1;
            if (is_alu) begin
                nx_opcode = i_opcode;
                nx_dr     = i_dr;
                nx_sr1    = alu_res;
                nx_pc     = i_pc;
            end else if (is_pass) begin
                nx_opcode = i_opcode;
                nx_dr     = i_dr;
                nx_sr1    = i_sr1_val;
                nx_sr2    = i_sr2_val;
                nx_imm    = i_imm;
                nx_pc     = i_pc;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (i_pipe_flush)
            state_nx = IDLE;
        else if (mul_start)
            state_nx = MUL_BUSY;
        else if (mul_done)
            state_nx = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt           <= 5'h0;
            mcand         <= 32'h0;
            mplier        <= 32'h0;
            prod          <= 32'h0;
            mul_dr        <= 4'h0;
            mul_pc        <= 32'h0;
            flush_reg     <= 1'b0;
            o_ld_newpc    <= 1'b0;
            o_br_pc       <= 32'h0;
            o_buf_opcode  <= 5'h0;
            o_buf_dr      <= 4'h0;
            o_buf_sr1_val <= 32'h0;
            o_buf_sr2_val <= 32'h0;
            o_buf_imm     <= 32'h0;
            o_buf_pc      <= 32'h0;
        end else if (i_pipe_flush) begin
            cnt           <= 5'h0;
            flush_reg     <= 1'b0;
            o_ld_newpc    <= 1'b0;
            o_buf_opcode  <= 5'h0;
            o_buf_dr      <= 4'h0;
            o_buf_sr1_val <= 32'h0;
            o_buf_sr2_val <= 32'h0;
            o_buf_imm     <= 32'h0;
            o_buf_pc      <= 32'h0;
        end else begin
            flush_reg  <= 1'b0;
            o_ld_newpc <= 1'b0;
            if (accept && br_taken) begin
                flush_reg  <= 1'b1;
                o_ld_newpc <= 1'b1;
                o_br_pc    <= br_target;
            end
            if (buf_ld) begin
                o_buf_opcode  <= nx_opcode;
                o_buf_dr      <= nx_dr;
                o_buf_sr1_val <= nx_sr1;
                o_buf_sr2_val <= nx_sr2;
                o_buf_imm     <= nx_imm;
                o_buf_pc      <= nx_pc;
            end
            if (mul_start) begin
                cnt    <= 5'h0;
                mcand  <= a;
                mplier <= b;
                prod   <= 32'h0;
                mul_dr <= i_dr;
                mul_pc <= i_pc;
            end else if ((state == MUL_BUSY) && (cnt != 5'd31)) begin
                prod   <= mul_res;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
            end
        end
    end

    always_comb begin
        o_fwd_dr  = 4'h0;
        o_fwd_val = 32'h0;
        if ((o_buf_opcode >= OP_ADD) && (o_buf_opcode <= OP_SHRA)) begin
            o_fwd_dr  = o_buf_dr;
            o_fwd_val = o_buf_sr1_val;
        end
    end

endmodule
